// File: rtl/avalon_mm_pkg.sv
// rtl/avalon_mm_pkg.sv - CSR map, default read word and FSM encodings shared by the DDR3 sample masters
package avalon_mm_pkg;

  localparam logic [2:0] CSR_BASE  = 3'd0;
  localparam logic [2:0] CSR_LEN   = 3'd1;
  localparam logic [2:0] CSR_STEP  = 3'd2;
  localparam logic [2:0] CSR_COUNT = 3'd3;
  localparam logic [2:0] CSR_START = 3'd4;
  localparam logic [2:0] CSR_DONE  = 3'd5;
  localparam logic [2:0] CSR_SRST  = 3'd6;

  localparam logic [31:0] CSR_DEFAULT = 32'hDEADBEEF;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] length;
    logic [31:0] step;
  } csr_t;

endpackage

// File: rtl/read_master_if.sv
// rtl/read_master_if.sv - Avalon-MM read bus between the sample reader and the DDR3 slave
interface read_master_if;

  logic               ddr_waitrequest;
  logic [31:0]        ddr_addr;
  logic               ddr_read;
  logic signed [15:0] ddr_readdata;
  logic               ddr_readdatavalid;

  modport master (
    input  ddr_waitrequest, ddr_readdata, ddr_readdatavalid,
    output ddr_addr, ddr_read
  );

  modport slave (
    output ddr_waitrequest, ddr_readdata, ddr_readdatavalid,
    input  ddr_addr, ddr_read
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with clear and occupancy count
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;
  logic             wr;
  logic             rd;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  // A simultaneous pop frees the slot on full; a simultaneous push feeds the pop on empty.
  assign wr    = push && (!full || pop);
  assign rd    = pop && (!empty || push);
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/read_master.sv
// rtl/read_master.sv - CSR-programmed DDR3 sample reader with credit-limited FIFO; READ_MASTER_LOOP_EN enables continuous playback
module read_master
  import avalon_mm_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  read_master_if.master      ddr,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [2:0]         addr,
  input  logic               read,
  input  logic               write,
  output logic signed [15:0] d_out,
  output logic               v,
  input  logic               rdy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  csr_t          csr;
  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [31:0]   issue_addr;
  logic [31:0]   issue_cnt;
  logic [31:0]   cnt_n;
  logic [31:0]   delivered;
  logic [31:0]   csr_rd;
  logic          done;
  logic          flush;
  logic          ddr_read_q;
  logic          read_n;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_n;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] fifo_n;
  logic [CW:0]   credit_sum;
  logic [15:0]   fifo_rdata;
  logic          fifo_empty;
  logic          start;
  logic          srst;
  logic          go;
  logic          wrap;
  logic          relatch;
  logic          accept;
  logic          push;
  logic          pop;

  assign start   = write && (addr == CSR_START);
  assign srst    = write && (addr == CSR_SRST);
  assign go      = start && (outstanding == '0) && ((state == IDLE) || (state == DONE));
`ifdef READ_MASTER_LOOP_EN
  assign wrap    = (state == DRAIN) && (delivered == csr.length);
`else
  assign wrap    = 1'b0;
`endif
  assign relatch = go || wrap;
  assign accept  = ddr_read_q && !ddr.ddr_waitrequest;
  // Beats from a run killed by soft reset are still counted but never buffered.
  assign push    = ddr.ddr_readdatavalid && !flush;
  assign pop     = v && rdy;

  assign out_n      = outstanding + CW'(accept) - CW'(ddr.ddr_readdatavalid);
  assign fifo_n     = fifo_count + CW'(push) - CW'(pop);
  assign credit_sum = {1'b0, out_n} + {1'b0, fifo_n};
  assign cnt_n      = relatch ? 32'd0 : issue_cnt + 32'(accept);

  assign ddr.ddr_addr = issue_addr;
  assign ddr.ddr_read = ddr_read_q;
  assign v            = !fifo_empty;
  assign d_out        = fifo_rdata;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (go) state_n = ISSUE;
      ISSUE:   if (issue_cnt == csr.length) state_n = DRAIN;
      DRAIN: begin
        if (wrap) state_n = ISSUE;
        else if (delivered == csr.length) state_n = DONE;
      end
      DONE:    if (go) state_n = ISSUE;
      default: state_n = IDLE;
    endcase
  end

  // The request is decided one cycle ahead from next-cycle counts so it can be registered.
  assign read_n = (ddr_read_q && ddr.ddr_waitrequest) ||
                  ((state_n == ISSUE) && (cnt_n < csr.length) && (credit_sum < LIMIT));

  always_comb begin
    case (addr)
      CSR_BASE:  csr_rd = csr.base;
      CSR_LEN:   csr_rd = csr.length;
      CSR_STEP:  csr_rd = csr.step;
      CSR_COUNT: csr_rd = delivered;
      CSR_DONE:  csr_rd = {31'b0, done};
      default:   csr_rd = CSR_DEFAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || srst) begin
      csr        <= '{base: 32'd0, length: 32'd0, step: 32'd1};
      state      <= IDLE;
      issue_addr <= 32'd0;
      issue_cnt  <= 32'd0;
      delivered  <= 32'd0;
      done       <= 1'b0;
      ddr_read_q <= 1'b0;
      readdata   <= 32'd0;
    end else begin
      state      <= state_n;
      ddr_read_q <= read_n;
      if (write) begin
        case (addr)
          CSR_BASE: csr.base   <= writedata;
          CSR_LEN:  csr.length <= writedata;
          CSR_STEP: csr.step   <= writedata;
          default: ;
        endcase
      end
      if (relatch) begin
        issue_addr <= csr.base;
        issue_cnt  <= 32'd0;
        delivered  <= 32'd0;
        done       <= 1'b0;
      end else begin
        if (accept) begin
          issue_addr <= issue_addr + csr.step;
          issue_cnt  <= cnt_n;
        end
        if (pop) delivered <= delivered + 32'd1;
      end
      if ((state == DRAIN) && (state_n == DONE)) done <= 1'b1;
      if (read) readdata <= csr_rd;
    end
  end

  // Outstanding survives soft reset so late beats can be recognised and discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      flush       <= 1'b0;
    end else begin
      outstanding <= out_n;
      flush       <= (srst || flush) && (out_n != '0);
    end
  end

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (srst),
    .push  (push),
    .wdata (ddr.ddr_readdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: doc/read_master.md
# read_master

Streaming DDR3 reader: the downstream counterpart of the DDR3 sample writer. Fetches a CSR-programmed run of 16-bit signed samples from DDR3 over an Avalon-MM read master. Buffers them in a credit-limited FIFO and presents them as a valid/ready sample stream to the LPC processing chain. Uses the same CSR map and start/done/soft-reset style as the writer, so software drives both identically.

## Interface
- `DEPTH`, 16: FIFO depth, power of 2, ≥ 4; also the maximum number of reads in flight plus buffered samples.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `ddr_waitrequest` in 1: DDR3 slave stall.
- `ddr_addr` out 32: read word address.
- `ddr_read` out 1: read request.
- `ddr_readdata` in 16: signed sample returned.
- `ddr_readdatavalid` in 1: `ddr_readdata` valid.
- `writedata` in 32: CSR write data.
- `readdata` out 32: CSR read data.
- `addr` in 3: CSR word address.
- `read` in 1: CSR read strobe.
- `write` in 1: CSR write strobe.
- `d_out` out 16: signed output sample.
- `v` out 1: `d_out` valid.
- `rdy` in 1: downstream accepts.

## Operation
- CSR map:
  - 0: base address, RW, reset 0.
  - 1: length in samples, RW, reset 0.
  - 2: step, RW, reset 1.
  - 3: delivered count, RO.
  - 4: start, W.
  - 5: done, RO, `{31'b0,done}`.
  - 6: soft reset, W.
  - 7 and reads of 4/6: return `32'hDEADBEEF`. Writes to 3/5/7 are ignored.
- Soft reset (`write`, addr 6) behaves like `rst` for CSRs, state, FIFO and counters, except the outstanding-read count. Beats still in flight are dropped on arrival until that count reaches 0.
- FSM states:
  - `IDLE`: on start, latch `issue_addr=base`, clear issue_cnt, delivered and done → `ISSUE`. Start is ignored while outstanding ≠ 0.
  - `ISSUE`: assert `ddr_read` with `ddr_addr=issue_addr` while `issue_cnt<length` and `outstanding+fifo_count<DEPTH`. On `ddr_read && !ddr_waitrequest`: `issue_addr+=step` (32-bit, wraps mod 2^32), `issue_cnt++`. When `issue_cnt==length` → `DRAIN`.
  - `DRAIN`: when `delivered==length` → `DONE`.
  - `DONE`: `done=1`. Start → `ISSUE` (re-latch as in `IDLE`, clear done).
- Start while in `ISSUE`/`DRAIN` is ignored.
- Length 0: start → `ISSUE` → `DRAIN` → `DONE`, with no DDR traffic.
- Each `ddr_readdatavalid` beat is pushed into the FIFO. The credit rule guarantees no overflow; an overflow is a design error, flagged by an assertion in simulation.
- FIFO is show-ahead: `v` = not empty and `d_out` = head. A pop happens on `v && rdy` and increments delivered (32-bit).
- Simultaneous push and pop on a full or empty FIFO is legal and keeps the count.
- Simultaneous CSR write and start in one cycle is impossible (single `addr`). A start write uses the CSR values already registered.

## Timing
- Reset values: `ddr_addr=0`, `ddr_read=0`, `readdata=0`, `d_out=0`, `v=0`, done=0, state `IDLE`.
- CSR read latency is 1 cycle (`readdata` registered); `readdata` holds between reads.
- Start written in cycle N → `ddr_read` high in cycle N+1, provided credits are available.
- `ddr_addr`/`ddr_read` are registered and held stable while `ddr_waitrequest` is high.
- Issue throughput is 1 request/cycle when unstalled.
- `ddr_readdatavalid` in cycle M → `v` high in cycle M+1.
- Output throughput is 1 sample/cycle with `rdy` held high.
- Last pop in cycle P → `done` reads 1 on a CSR read issued in cycle P+2 or later.

## Configuration
- `READ_MASTER_LOOP_EN` defined: on reaching `DONE` conditions, the FSM instead re-latches base, clears issue_cnt and delivered, and returns to `ISSUE` in the next cycle.
  - This gives continuous playback; done stays 0.
  - Only soft reset or `rst` stops it.
- Not defined: one-shot behaviour as above.

## Structure
- Shared package `avalon_mm_pkg`:
  - CSR address constants (0–6);
  - the `32'hDEADBEEF` default;
  - FSM state encodings (`IDLE`=0, `ISSUE`=1, `DRAIN`=2, `DONE`=3).
- Sub-module `sync_fifo` (parameters `WIDTH=16`, `DEPTH`): show-ahead, synchronous clear, exposes `count`. The credit logic lives in `read_master`.

## Test plan
- Base 0x100, len 4, step 2, `rdy=1`, zero-wait slave → addresses 0x100/102/104/106, 4 samples out in order, done=1, reg 3 reads 4.
- Same run with `ddr_waitrequest` high 3 cycles on the 2nd request → `ddr_addr` stays 0x102 and `ddr_read` stays high during the stall, and the output is unchanged.
- `rdy=0` with `DEPTH=16`, len 40 → exactly 16 requests issued then `ddr_read` low. Releasing `rdy` yields all 40 samples, no loss.
- Len 0, start → no `ddr_read`; done=1 within 4 cycles.
- Soft reset after 5 requests with 3 in flight → CSRs reset, 3 late beats dropped (`v` stays 0), start ignored until drained, then the next run is clean.
- `READ_MASTER_LOOP_EN`, len 3 → addresses cycle base, base+1, base+2 repeatedly; done stays 0.
